sprite_color_mapper: RTL and testbench

Pipelined pixel colour generator for the PacMan display path. It replaces the single-ball colour mapper with a parametrised multi-sprite compositor: NUM_SPRITES priority-ordered 16×16 sprites over a ROM-backed maze. It has a writable 16-entry palette and frame-driven animation (PacMan mouth cycle, ghost wiggle, frightened blink). It sits between the VGA controller (DrawX/DrawY/blank) and the VGA DAC outputs.

---
 rtl/sprite_color_mapper_if.sv | 13 +
 rtl/sprite_color_mapper.sv | 269 ++++++++++++++++++++++++++
 tb/tb_sprite_color_mapper.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_color_mapper_if.sv
// Pixel bus between the VGA timing generator and the colour mapper:
// pixel coordinate and blank in, registered RGB out.
interface sprite_color_mapper_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic [7:0] Red;
  logic [7:0] Green;
  logic [7:0] Blue;

  modport master (output DrawX, DrawY, blank, input Red, Green, Blue);
  modport slave  (input DrawX, DrawY, blank, output Red, Green, Blue);
endinterface

// File: rtl/sprite_color_mapper.sv
// Three-stage pixel colour pipeline: priority-ordered sprites over a ROM maze,
// writable 16-entry palette, and frame-driven PacMan/ghost animation.
module sprite_color_mapper #(
  parameter int unsigned NUM_SPRITES = 5,
  parameter int unsigned SPRITE_SIZE = 16,
  parameter int unsigned MAP_W       = 224,
  parameter int unsigned MAP_H       = 248,
  parameter int unsigned MAP_X0      = 208,
  parameter int unsigned MAP_Y0      = 116,
  parameter int unsigned ANIM_DIV    = 4,
  localparam int unsigned IW         = $clog2(NUM_SPRITES),
  localparam int unsigned LW         = $clog2(SPRITE_SIZE),
  localparam int unsigned SA         = IW + 2 + 2 * LW
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  sprite_color_mapper_if.slave       bus,
  input  logic                       frame_start,
  input  logic [10*NUM_SPRITES-1:0]  SpriteX,
  input  logic [10*NUM_SPRITES-1:0]  SpriteY,
  input  logic [NUM_SPRITES-1:0]     SpriteEn,
  input  logic                       frightened,
  input  logic                       fright_ending,
  output logic [SA-1:0]              sprite_rom_addr,
  input  logic [3:0]                 sprite_rom_data,
  output logic [15:0]                maze_rom_addr,
  input  logic [3:0]                 maze_rom_data,
  input  logic                       pal_we,
  input  logic [3:0]                 pal_addr,
  input  logic [23:0]                pal_data
);

  localparam int unsigned CW     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CW-1:0] CntMax = CW'(ANIM_DIV - 1);
  localparam logic [9:0] SizeW   = 10'(SPRITE_SIZE);
  localparam logic [9:0] MapX0   = 10'(MAP_X0);
  localparam logic [9:0] MapY0   = 10'(MAP_Y0);
  localparam logic [9:0] MapW    = 10'(MAP_W);
  localparam logic [9:0] MapH    = 10'(MAP_H);

  typedef enum logic [1:0] {StOpen, StHalfC, StClosed, StHalfO} mouth_e;

  function automatic logic [23:0] pal_init(input logic [3:0] idx);
    case (idx)
      4'd1:    return 24'h2121DE;
      4'd2:    return 24'hFFFF00;
      4'd3:    return 24'hFFB8AE;
      4'd4:    return 24'h2121FF;
      4'd5:    return 24'hFFFFFF;
      default: return 24'h000000;
    endcase
  endfunction

  // ---------------------------------------------------------------- animation
  mouth_e        mouth_q, mouth_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wiggle_q, wiggle_d;
  logic          blink_q, blink_d;
  logic          anim_tick;
  logic [1:0]    mouth_frame;

  assign anim_tick = frame_start && (cnt_q == CntMax);

  always_comb begin
    cnt_d    = cnt_q;
    wiggle_d = wiggle_q;
    blink_d  = blink_q;
    if (frame_start) begin
      cnt_d = anim_tick ? '0 : cnt_q + 1'b1;
    end
    if (anim_tick) begin
      wiggle_d = ~wiggle_q;
      blink_d  = ~blink_q;
    end
    if (!frightened) begin
      blink_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q    <= '0;
      wiggle_q <= 1'b0;
      blink_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wiggle_q <= wiggle_d;
      blink_q  <= blink_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mouth_q <= StOpen;
    end else begin
      mouth_q <= mouth_d;
    end
  end

  always_comb begin
    mouth_d = mouth_q;
    if (anim_tick) begin
      unique case (mouth_q)
        StOpen:   mouth_d = StHalfC;
        StHalfC:  mouth_d = StClosed;
        StClosed: mouth_d = StHalfO;
        StHalfO:  mouth_d = StOpen;
        default:  mouth_d = StOpen;
      endcase
    end
  end

  always_comb begin
    unique case (mouth_q)
      StOpen:   mouth_frame = 2'd0;
      StClosed: mouth_frame = 2'd2;
      default:  mouth_frame = 2'd1;
    endcase
  end

  // ---------------------------------------------------------------- S1: hit test
  logic [NUM_SPRITES-1:0] hit;
  logic [9:0]             off_x [NUM_SPRITES];
  logic [9:0]             off_y [NUM_SPRITES];

  // Unsigned offsets wrap when the sprite lies right of/below the pixel, so
  // the >= guard is what rejects those.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      off_x[i] = bus.DrawX - SpriteX[10*i +: 10];
      off_y[i] = bus.DrawY - SpriteY[10*i +: 10];
      hit[i]   = SpriteEn[i] &&
                 (bus.DrawX >= SpriteX[10*i +: 10]) && (off_x[i] < SizeW) &&
                 (bus.DrawY >= SpriteY[10*i +: 10]) && (off_y[i] < SizeW);
    end
  end

  logic          hit_any;
  logic [IW-1:0] win_idx;
  logic [LW-1:0] win_lx, win_ly;
  logic [1:0]    win_frame;

  // Scan high to low so the lowest-index hitting sprite ends up the winner.
  always_comb begin
    hit_any = 1'b0;
    win_idx = '0;
    win_lx  = '0;
    win_ly  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        win_idx = IW'(i);
        win_lx  = off_x[i][LW-1:0];
        win_ly  = off_y[i][LW-1:0];
      end
    end
  end

  always_comb begin
    if (win_idx == '0) begin
      win_frame = mouth_frame;
    end else if (!frightened) begin
      win_frame = {1'b0, wiggle_q};
    end else if (fright_ending) begin
      win_frame = {1'b1, blink_q};
    end else begin
      win_frame = 2'd2;
    end
  end

  logic [9:0]  maze_x, maze_y;
  logic        maze_on;
  logic [15:0] maze_addr_d;
  logic [SA-1:0] spr_addr_d;

  assign maze_x  = bus.DrawX - MapX0;
  assign maze_y  = bus.DrawY - MapY0;
  assign maze_on = (bus.DrawX >= MapX0) && (maze_x < MapW) &&
                   (bus.DrawY >= MapY0) && (maze_y < MapH);
  assign maze_addr_d = maze_on ? 16'((32'(maze_y) * MAP_W) + 32'(maze_x)) : 16'h0;
  assign spr_addr_d  = hit_any ? {win_idx, win_frame, win_ly, win_lx} : '0;

  logic [SA-1:0] spr_addr_q;
  logic [15:0]   maze_addr_q;
  logic          s1_hit_q, s1_maze_q, s1_blank_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      spr_addr_q  <= '0;
      maze_addr_q <= '0;
      s1_hit_q    <= 1'b0;
      s1_maze_q   <= 1'b0;
      s1_blank_q  <= 1'b0;
    end else begin
      spr_addr_q  <= spr_addr_d;
      maze_addr_q <= maze_addr_d;
      s1_hit_q    <= hit_any;
      s1_maze_q   <= maze_on;
      s1_blank_q  <= bus.blank;
    end
  end

  assign sprite_rom_addr = spr_addr_q;
  assign maze_rom_addr   = maze_addr_q;

  // ---------------------------------------------------------------- S2: align flags with ROM data
  logic s2_hit_q, s2_maze_q, s2_blank_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_hit_q   <= 1'b0;
      s2_maze_q  <= 1'b0;
      s2_blank_q <= 1'b0;
    end else begin
      s2_hit_q   <= s1_hit_q;
      s2_maze_q  <= s1_maze_q;
      s2_blank_q <= s1_blank_q;
    end
  end

  // ---------------------------------------------------------------- palette
  logic [23:0] pal_q [16];
  logic [23:0] pal_d [16];

  always_comb begin
    pal_d = pal_q;
    if (pal_we) begin
      pal_d[pal_addr] = pal_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) begin
        pal_q[i] <= pal_init(4'(i));
      end
    end else begin
      pal_q <= pal_d;
    end
  end

  // ---------------------------------------------------------------- S3: colour select
  logic [23:0] rgb_q, rgb_d;

  // Palette read sees pre-write contents, so a same-cycle write shows next pixel.
  always_comb begin
    rgb_d = 24'h000000;
    if (s2_blank_q) begin
      if (s2_hit_q && (sprite_rom_data != 4'h0)) begin
        rgb_d = pal_q[sprite_rom_data];
      end else if (s2_maze_q) begin
        rgb_d = pal_q[maze_rom_data];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q <= 24'h000000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign bus.Red   = rgb_q[23:16];
  assign bus.Green = rgb_q[15:8];
  assign bus.Blue  = rgb_q[7:0];

endmodule

// File: tb/tb_sprite_color_mapper.sv
// Directed bench for sprite_color_mapper: synchronous ROM stubs, a pixel-level
// reference model checked every clock, and hand-computed literal checks.
module tb_sprite_color_mapper;
  localparam int N  = 5;
  localparam int AD = 4;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        frame_start = 1'b0;
  logic [49:0] SpriteX = '0;
  logic [49:0] SpriteY = '0;
  logic [4:0]  SpriteEn = '0;
  logic        frightened = 1'b0;
  logic        fright_ending = 1'b0;
  logic [12:0] sprite_rom_addr;
  logic [3:0]  sprite_rom_data = '0;
  logic [15:0] maze_rom_addr;
  logic [3:0]  maze_rom_data = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = '0;
  logic [23:0] pal_data = '0;

  logic [3:0] srom [8192];
  logic [3:0] mrom [65536];

  sprite_color_mapper_if vif ();

  sprite_color_mapper #(
    .NUM_SPRITES(N), .SPRITE_SIZE(16), .MAP_W(224), .MAP_H(248),
    .MAP_X0(208), .MAP_Y0(116), .ANIM_DIV(AD)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(vif), .frame_start(frame_start),
    .SpriteX(SpriteX), .SpriteY(SpriteY), .SpriteEn(SpriteEn),
    .frightened(frightened), .fright_ending(fright_ending),
    .sprite_rom_addr(sprite_rom_addr), .sprite_rom_data(sprite_rom_data),
    .maze_rom_addr(maze_rom_addr), .maze_rom_data(maze_rom_data),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    sprite_rom_data <= srom[sprite_rom_addr];
    maze_rom_data   <= mrom[maze_rom_addr];
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] m_pal [16];
  int          pipe [$];
  int          m_pulses = 0;
  int          m_blink  = 0;
  int          mouth_tab [4] = '{0, 1, 2, 1};
  int          mouth_exp [5] = '{0, 1, 2, 1, 0};
  int          ghost_exp [4] = '{2, 3, 2, 3};

  function automatic logic [23:0] pal_rst(input int i);
    case (i)
      1:       return 24'h2121DE;
      2:       return 24'hFFFF00;
      3:       return 24'hFFB8AE;
      4:       return 24'h2121FF;
      5:       return 24'hFFFFFF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] rgb_now();
    return {vif.Red, vif.Green, vif.Blue};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pal[i] = pal_rst(i);
    pipe.delete();
    pipe.push_back(-1);
    pipe.push_back(-1);
    m_pulses = 0;
    m_blink  = 0;
  endtask

  // What the current inputs must produce: ROM addresses and palette index (-1 = black).
  task automatic model_pixel(output bit hit, output int saddr, output int maddr,
                             output int cidx);
    int x, y, sx, sy, win, frame, ticks, mx, my;
    bit mon;
    x = int'(vif.DrawX);
    y = int'(vif.DrawY);
    win = -1;
    for (int i = N - 1; i >= 0; i--) begin
      sx = int'(SpriteX[10*i +: 10]);
      sy = int'(SpriteY[10*i +: 10]);
      if (SpriteEn[i] && x >= sx && x < sx + 16 && y >= sy && y < sy + 16) win = i;
    end
    ticks = m_pulses / AD;
    if (win == 0)              frame = mouth_tab[ticks % 4];
    else if (!frightened)      frame = ticks % 2;
    else if (fright_ending)    frame = 2 + m_blink;
    else                       frame = 2;
    hit   = (win >= 0);
    saddr = 0;
    if (hit) begin
      sx = int'(SpriteX[10*win +: 10]);
      sy = int'(SpriteY[10*win +: 10]);
      saddr = win * 1024 + frame * 256 + (y - sy) * 16 + (x - sx);
    end
    mx = x - 208;
    my = y - 116;
    mon = (mx >= 0) && (mx < 224) && (my >= 0) && (my < 248);
    maddr = mon ? (my * 224 + mx) % 65536 : 0;
    if (!vif.blank)                      cidx = -1;
    else if (hit && srom[saddr] != 4'h0) cidx = int'(srom[saddr]);
    else if (mon)                        cidx = int'(mrom[maddr]);
    else                                 cidx = -1;
  endtask

  // One pixel clock: predict, advance model state, clock, compare.
  task automatic cyc();
    bit hit;
    int saddr, maddr, cidx, e;
    logic [23:0] exp_rgb;
    model_pixel(hit, saddr, maddr, cidx);
    pipe.push_back(cidx);
    e = pipe.pop_front();
    exp_rgb = (e < 0) ? 24'h0 : m_pal[e];
    if (pal_we) m_pal[pal_addr] = pal_data;
    if (frame_start) begin
      m_pulses++;
      if (frightened && (m_pulses % AD == 0)) m_blink ^= 1;
    end
    if (!frightened) m_blink = 0;
    @(posedge Clk);
    #1;
    check("maze_rom_addr", 32'(maze_rom_addr), 32'(maddr));
    if (hit) check("sprite_rom_addr", 32'(sprite_rom_addr), 32'(saddr));
    check("rgb", 32'(rgb_now()), 32'(exp_rgb));
  endtask

  task automatic do_reset(input bit fs);
    Reset_n = 1'b0;
    frame_start = fs;
    model_reset();
    #1;
    check("reset_rgb", 32'(rgb_now()), 32'h0);
    check("reset_maze_addr", 32'(maze_rom_addr), 32'h0);
    check("reset_sprite_addr", 32'(sprite_rom_addr), 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    frame_start = 1'b0;
    Reset_n = 1'b1;
  endtask

  task automatic set_sprite(input int i, input int x, input int y);
    SpriteX[10*i +: 10] = 10'(x);
    SpriteY[10*i +: 10] = 10'(y);
  endtask

  task automatic pulses(input int n);
    for (int p = 0; p < n; p++) begin
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
      cyc();
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++)  srom[i] = 4'((i * 7 + 3) % 16);
    for (int i = 0; i < 65536; i++) mrom[i] = 4'(i % 6);
    srom[19]    = 4'd2;
    srom[20]    = 4'd0;
    srom[1043]  = 4'd4;
    mrom[453]   = 4'd1;
    mrom[19136] = 4'd3;
    vif.DrawX = '0;
    vif.DrawY = '0;
    vif.blank = 1'b1;

    #2;
    do_reset(1'b1);

    // Empty screen corner.
    repeat (3) cyc();
    check("lit_black_rgb", 32'(rgb_now()), 32'h0);
    check("lit_black_maze_addr", 32'(maze_rom_addr), 32'h0);

    // Maze pixel (5,2) inside the map.
    vif.DrawX = 10'd213;
    vif.DrawY = 10'd118;
    cyc();
    check("lit_maze_addr_453", 32'(maze_rom_addr), 32'd453);
    repeat (2) cyc();
    check("lit_maze_rgb", 32'(rgb_now()), 32'h2121DE);

    // Overlapping sprites 0 and 1: PacMan wins.
    set_sprite(0, 300, 200);
    set_sprite(1, 300, 200);
    SpriteEn  = 5'b00011;
    vif.DrawX = 10'd303;
    vif.DrawY = 10'd201;
    cyc();
    check("lit_sprite_addr_19", 32'(sprite_rom_addr), 32'd19);
    repeat (2) cyc();
    check("lit_sprite_rgb", 32'(rgb_now()), 32'hFFFF00);
    vif.DrawX = 10'd304;
    repeat (3) cyc();
    check("lit_transparent_maze", 32'(rgb_now()), 32'hFFB8AE);
    SpriteEn  = 5'b00010;
    vif.DrawX = 10'd303;
    repeat (3) cyc();
    check("lit_ghost_addr", 32'(sprite_rom_addr), 32'd1043);
    check("lit_ghost_rgb", 32'(rgb_now()), 32'h2121FF);

    // Sprite edges, wrap-around rejection and maze borders.
    set_sprite(2, 500, 300);
    set_sprite(3, 1020, 5);
    set_sprite(4, 200, 110);
    SpriteEn = 5'b11100;
    foreach (mouth_tab[k]) begin
      for (int x = 497; x <= 518; x++) begin
        vif.DrawX = 10'(x);
        vif.DrawY = 10'(299 + (k % 2) + 15 * (k / 2));
        vif.blank = (x % 5 != 0);
        cyc();
      end
    end
    vif.blank = 1'b1;
    for (int x = 0; x <= 6; x++) begin
      vif.DrawX = 10'(x);
      vif.DrawY = 10'd10;
      cyc();
    end
    for (int xi = 0; xi < 8; xi++) begin
      for (int yi = 0; yi < 8; yi++) begin
        vif.DrawX = 10'((xi < 4) ? 206 + xi : 426 + xi);
        vif.DrawY = 10'((yi < 4) ? 114 + yi : 358 + yi);
        cyc();
      end
    end

    // Mouth cycle, then ghost frames under frightened mode.
    SpriteEn  = 5'b00011;
    vif.DrawX = 10'd303;
    vif.DrawY = 10'd201;
    for (int t = 0; t < 5; t++) begin
      cyc();
      check("lit_mouth_frame", 32'(sprite_rom_addr[9:8]), 32'(mouth_exp[t]));
      if (t < 4) pulses(AD);
    end
    SpriteEn = 5'b00010;
    cyc();
    frightened    = 1'b1;
    fright_ending = 1'b1;
    for (int t = 0; t < 4; t++) begin
      cyc();
      check("lit_ghost_frame", 32'(sprite_rom_addr[9:8]), 32'(ghost_exp[t]));
      if (t < 3) pulses(AD);
    end
    fright_ending = 1'b0;
    cyc();
    check("lit_fright_frame", 32'(sprite_rom_addr[9:8]), 32'd2);
    pulses(2);
    frightened = 1'b0;
    SpriteEn   = 5'b00011;
    repeat (3) cyc();

    // Palette write while entry 2 is being read.
    SpriteEn  = 5'b00000;
    vif.DrawX = 10'd212;
    vif.DrawY = 10'd118;
    repeat (3) cyc();
    check("lit_pal2_before", 32'(rgb_now()), 32'hFFFF00);
    pal_we   = 1'b1;
    pal_addr = 4'd2;
    pal_data = 24'h00FF00;
    cyc();
    pal_we = 1'b0;
    check("lit_pal2_same_cycle", 32'(rgb_now()), 32'hFFFF00);
    cyc();
    check("lit_pal2_written", 32'(rgb_now()), 32'h00FF00);

    // Asynchronous reset mid-line with a full pipeline.
    cyc();
    #3;
    do_reset(1'b1);
    repeat (3) cyc();
    check("lit_pal2_restored", 32'(rgb_now()), 32'hFFFF00);
    SpriteEn  = 5'b00001;
    vif.DrawX = 10'd303;
    vif.DrawY = 10'd201;
    pulses(3);
    cyc();
    check("lit_mouth_after_reset", 32'(sprite_rom_addr[9:8]), 32'd0);
    pulses(1);
    cyc();
    check("lit_mouth_tick_after_reset", 32'(sprite_rom_addr[9:8]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
